// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers and countdown sequencer for the E stage.
// Define MDU_DIVZERO_KEEP_EN to leave HI/LO untouched on a divide by zero.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        DMdUse,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        MdStall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdOp_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            stateReg, stateNext;
  logic [CNT_W-1:0]  cntReg, cntNext;
  mdOp_t             opReg, opNext;
  logic [31:0]       aReg, aNext;
  logic [31:0]       bReg, bNext;
  logic [31:0]       hiReg, hiNext;
  logic [31:0]       loReg, loNext;

  mdOp_t             opIn;
  logic              isStartOp;
  logic              start;

  assign opIn      = mdOp_t'(MdOp);
  assign isStartOp = (opIn == OP_MULT) || (opIn == OP_MULTU) ||
                     (opIn == OP_DIV)  || (opIn == OP_DIVU);
  assign start     = isStartOp && (stateReg == IDLE);

  // Result datapath works from the operands latched at the start edge.
  logic        isSigned;
  logic [63:0] mulA, mulB, product;
  logic        aNeg, bNeg;
  logic [31:0] aMag, bMag, quoMag, remMag, quo, rem;
  logic        divZero;
  logic [31:0] resHi, resLo;

  assign isSigned = (opReg == OP_MULT) || (opReg == OP_DIV);
  assign mulA     = isSigned ? {{32{aReg[31]}}, aReg} : {32'd0, aReg};
  assign mulB     = isSigned ? {{32{bReg[31]}}, bReg} : {32'd0, bReg};
  assign product  = mulA * mulB;

  // Signed divide via magnitudes: the 0x80000000 / -1 case falls out naturally.
  assign aNeg    = isSigned & aReg[31];
  assign bNeg    = isSigned & bReg[31];
  assign aMag    = aNeg ? (~aReg + 32'd1) : aReg;
  assign bMag    = bNeg ? (~bReg + 32'd1) : bReg;
  assign divZero = (bReg == 32'd0);
  assign quoMag  = divZero ? 32'd0 : (aMag / bMag);
  assign remMag  = divZero ? 32'd0 : (aMag % bMag);
  assign quo     = (aNeg ^ bNeg) ? (~quoMag + 32'd1) : quoMag;
  assign rem     = aNeg ? (~remMag + 32'd1) : remMag;

  always_comb begin
    resHi = hiReg;
    resLo = loReg;
    case (opReg)
      OP_MULT, OP_MULTU: begin
        resHi = product[63:32];
        resLo = product[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (divZero) begin
`ifdef MDU_DIVZERO_KEEP_EN
          resHi = hiReg;
          resLo = loReg;
`else
          resHi = aReg;
          resLo = 32'hFFFF_FFFF;
`endif
        end else begin
          resHi = rem;
          resLo = quo;
        end
      end
      default: begin
        resHi = hiReg;
        resLo = loReg;
      end
    endcase
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    opNext    = opReg;
    aNext     = aReg;
    bNext     = bReg;
    hiNext    = hiReg;
    loNext    = loReg;
    case (stateReg)
      IDLE: begin
        if (start) begin
          opNext    = opIn;
          aNext     = A;
          bNext     = B;
          cntNext   = ((opIn == OP_DIV) || (opIn == OP_DIVU)) ?
                      CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          stateNext = RUN;
        end else if (opIn == OP_MTHI) begin
          hiNext = A;
        end else if (opIn == OP_MTLO) begin
          loNext = A;
        end
      end
      RUN: begin
        // Moves and new starts are ignored while running.
        if (cntReg <= CNT_W'(1)) begin
          cntNext   = '0;
          hiNext    = resHi;
          loNext    = resLo;
          stateNext = IDLE;
        end else begin
          cntNext = cntReg - CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      opReg    <= OP_NONE;
      aReg     <= '0;
      bReg     <= '0;
      hiReg    <= '0;
      loReg    <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      opReg    <= opNext;
      aReg     <= aNext;
      bReg     <= bNext;
      hiReg    <= hiNext;
      loReg    <= loNext;
    end
  end

  assign HI      = hiReg;
  assign LO      = loReg;
  assign Busy    = (stateReg == RUN);
  assign MdStall = DMdUse & (start | Busy);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: arithmetic reference model plus directed literal checks.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  MdOp = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        DMdUse = 1'b0;
  logic [31:0] HI, LO;
  logic        Busy, MdStall;

  int checks = 0;
  int errors = 0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .MdOp(MdOp), .A(A), .B(B), .DMdUse(DMdUse),
    .HI(HI), .LO(LO), .Busy(Busy), .MdStall(MdStall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic using the language's own signed/unsigned operators.
  task automatic calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] hi, output logic [31:0] lo, output logic wr);
    longint           sp;
    logic [63:0]      up;
    logic signed [31:0] sa, sb;
    sa = a; sb = b; wr = 1'b1; hi = 32'd0; lo = 32'd0;
    case (op)
      3'd1: begin sp = longint'(sa) * longint'(sb); up = sp; hi = up[63:32]; lo = up[31:0]; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      3'd3, 3'd4: begin
        if (b == 32'd0) begin
`ifdef MDU_DIVZERO_KEEP_EN
          wr = 1'b0;
`else
          hi = a; lo = 32'hFFFF_FFFF;
`endif
        end else if (op == 3'd3) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000; hi = 32'd0;
          end else begin
            lo = sa / sb; hi = sa % sb;
          end
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      default: wr = 1'b0;
    endcase
  endtask

  logic [31:0] mHi = 32'd0, mLo = 32'd0, pHi = 32'd0, pLo = 32'd0;
  logic        pWrite = 1'b0;
  int          mRemain = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mHi = 32'd0; mLo = 32'd0; mRemain = 0; pWrite = 1'b0;
    end else if (mRemain > 0) begin
      mRemain--;
      if (mRemain == 0 && pWrite) begin mHi = pHi; mLo = pLo; end
    end else if (MdOp >= 3'd1 && MdOp <= 3'd4) begin
      calc(MdOp, A, B, pHi, pLo, pWrite);
      mRemain = (MdOp <= 3'd2) ? MULT_N : DIV_N;
    end else if (MdOp == 3'd5) begin
      mHi = A;
    end else if (MdOp == 3'd6) begin
      mLo = A;
    end
  end

  always @(negedge clk) begin
    logic expStart;
    expStart = (mRemain == 0) && (MdOp >= 3'd1) && (MdOp <= 3'd4);
    chk("model_HI", HI, mHi);
    chk("model_LO", LO, mLo);
    chk("model_Busy", {31'd0, Busy}, {31'd0, (mRemain > 0)});
    chk("model_MdStall", {31'd0, MdStall}, {31'd0, DMdUse & (expStart | (mRemain > 0))});
  end

  task automatic doOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    MdOp = op; A = a; B = b;
    @(posedge clk); #2;
    MdOp = 3'd0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    @(negedge clk);
    while (Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL busy_timeout: Busy still %b after %0d cycles", Busy, n);
    end
  endtask

  initial begin
    int n;
    @(negedge clk);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    chk("rst_Busy", {31'd0, Busy}, 32'd0);
    chk("rst_MdStall", {31'd0, MdStall}, 32'd0);
    @(posedge clk); #2; reset = 1'b0;

    doOp(3'd1, 32'hFFFF_FFFE, 32'd3); waitIdle(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFFA);
    $display("MULT  -2*3          HI=%h LO=%h busy=%0d", HI, LO, n);

    doOp(3'd2, 32'hFFFF_FFFF, 32'd2); waitIdle(n);
    chk("multu_HI", HI, 32'h0000_0001);
    chk("multu_LO", LO, 32'hFFFF_FFFE);
    $display("MULTU ffffffff*2    HI=%h LO=%h busy=%0d", HI, LO, n);

    doOp(3'd1, 32'h8000_0000, 32'h8000_0000); waitIdle(n);
    chk("mult_min_HI", HI, 32'h4000_0000);
    chk("mult_min_LO", LO, 32'h0000_0000);
    $display("MULT  min*min       HI=%h LO=%h busy=%0d", HI, LO, n);

    doOp(3'd3, 32'hFFFF_FFF9, 32'd2); waitIdle(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_LO", LO, 32'hFFFF_FFFD);
    chk("div_HI", HI, 32'hFFFF_FFFF);
    $display("DIV   -7/2          HI=%h LO=%h busy=%0d", HI, LO, n);

    // Back-to-back: DIVU by zero issued in the cycle Busy drops.
    #1; MdOp = 3'd4; A = 32'd7; B = 32'd0;
    @(posedge clk); #2; MdOp = 3'd0;
    waitIdle(n);
    chk("divz_cycles", 32'(n), 32'd10);
`ifdef MDU_DIVZERO_KEEP_EN
    chk("divz_LO", LO, 32'hFFFF_FFFD);
    chk("divz_HI", HI, 32'hFFFF_FFFF);
`else
    chk("divz_LO", LO, 32'hFFFF_FFFF);
    chk("divz_HI", HI, 32'h0000_0007);
`endif
    $display("DIVU  7/0           HI=%h LO=%h busy=%0d", HI, LO, n);

    doOp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); waitIdle(n);
    chk("div_ovf_LO", LO, 32'h8000_0000);
    chk("div_ovf_HI", HI, 32'h0000_0000);
    $display("DIV   min/-1        HI=%h LO=%h busy=%0d", HI, LO, n);

    doOp(3'd3, 32'd7, 32'hFFFF_FFFE); waitIdle(n);
    chk("div_neg_LO", LO, 32'hFFFF_FFFD);
    chk("div_neg_HI", HI, 32'h0000_0001);
    $display("DIV   7/-2          HI=%h LO=%h busy=%0d", HI, LO, n);

    doOp(3'd4, 32'd100, 32'd7); waitIdle(n);
    chk("divu_LO", LO, 32'd14);
    chk("divu_HI", HI, 32'd2);
    $display("DIVU  100/7         HI=%h LO=%h busy=%0d", HI, LO, n);

    // Stall window with DMdUse held; a second MULT arrives while busy.
    @(posedge clk); #2;
    DMdUse = 1'b1; MdOp = 3'd1; A = 32'h0001_0000; B = 32'h0003_0000;
    n = 0;
    @(negedge clk); if (MdStall) n++;
    @(posedge clk); #2; A = 32'd5; B = 32'd5;
    @(negedge clk); if (MdStall) n++;
    @(posedge clk); #2; MdOp = 3'd0;
    repeat (10) begin @(negedge clk); if (MdStall) n++; end
    #1; DMdUse = 1'b0;
    chk("stall_cycles", 32'(n), 32'd6);
    chk("stall_HI", HI, 32'd3);
    chk("stall_LO", LO, 32'd0);
    $display("MULT  stall window  HI=%h LO=%h stall=%0d", HI, LO, n);

    doOp(3'd5, 32'h1234_5678, 32'd0);
    @(negedge clk);
    chk("mthi_HI", HI, 32'h1234_5678);
    chk("mthi_Busy", {31'd0, Busy}, 32'd0);
    $display("MTHI  12345678      HI=%h Busy=%b", HI, Busy);

    doOp(3'd2, 32'd3, 32'd4);
    doOp(3'd6, 32'hDEAD_BEEF, 32'd0);
    waitIdle(n);
    chk("mtlo_busy_LO", LO, 32'd12);
    chk("mtlo_busy_HI", HI, 32'd0);
    $display("MTLO  while busy    HI=%h LO=%h", HI, LO);

    doOp(3'd5, 32'hAAAA_5555, 32'd0);
    doOp(3'd3, 32'd100, 32'd3);
    @(posedge clk);
    @(posedge clk); #2; reset = 1'b1;
    #1;
    chk("midrst_Busy", {31'd0, Busy}, 32'd0);
    chk("midrst_HI", HI, 32'd0);
    chk("midrst_LO", LO, 32'd0);
    @(posedge clk); #2; reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("postrst_HI", HI, 32'd0);
    chk("postrst_LO", LO, 32'd0);
    chk("postrst_Busy", {31'd0, Busy}, 32'd0);
    $display("RESET mid-DIV       HI=%h LO=%h Busy=%b", HI, LO, Busy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit with its HI/LO registers and the sequencer for them, sitting in the E stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo ops from the E-stage control word and models the multi-cycle latency with a countdown. It exposes HI/LO for mfhi/mflo and raises a stall request so the D stage holds any HI/LO-dependent instruction while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- MdOp  in  3  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- A  in  32  rs operand, forwarded
- B  in  32  rt operand, forwarded
- DMdUse  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- HI  out  32  HI register
- LO  out  32  LO register
- Busy  out  1  operation in flight
- MdStall  out  1  stall request to the hazard unit

## Operation
- Start = MdOp ∈ {1,2,3,4} and Busy=0. Start with Busy=1 is a protocol violation: ignored, no state change.
- States: IDLE (Busy=0), RUN (Busy=1). Counter cnt, 4 bits minimum, wide enough for max(MULT_CYCLES, DIV_CYCLES).
- IDLE + Start:
  - Latch op, A, B.
  - cnt ← MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN: cnt decrements each cycle. On the edge where cnt goes 1→0:
  - Write HI/LO.
  - Go to IDLE.
- MULT: {HI,LO} ← signed(A)×signed(B), 64-bit.
- MULTU: {HI,LO} ← unsigned 64-bit product.
- DIV: LO ← quotient truncated toward zero; HI ← remainder with the sign of the dividend.
- DIVU: unsigned quotient to LO, unsigned remainder to HI.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero: see Configuration.
- MTHI/MTLO in IDLE: HI (resp. LO) ← A at the next edge. No Busy.
- MTHI/MTLO while Busy: ignored.
- MdStall = DMdUse & (Start | Busy).

## Timing
- Reset values: HI=0, LO=0, Busy=0, MdStall=0 (given DMdUse=0), cnt=0, state IDLE.
- Start accepted in cycle T. Busy=1 in cycles T+1 … T+N, with N = MULT_CYCLES or DIV_CYCLES.
- New HI/LO visible in cycle T+N+1, the same cycle Busy drops.
- A D-stage mfhi stalled during the op issues in cycle T+N+1 and reads E-stage HI in T+N+2.
- MdStall is combinational. It is high in cycle T (through Start) and in cycles T+1 … T+N (through Busy).
- Back-to-back: a new Start is legal in cycle T+N+1.
- MTHI/MTLO: single-cycle; the value is visible the cycle after the op sits in E.
- Reset asserted mid-RUN: immediately returns to IDLE, clears HI/LO, and discards the pending result. No write occurs after reset deasserts.
- A, B and MdOp are sampled only at the Start edge. Changes during RUN have no effect.

## Configuration
- MDU_DIVZERO_KEEP_EN:
  - Defined: DIV/DIVU with B=0 still runs DIV_CYCLES with Busy, then leaves HI and LO unchanged.
  - Undefined: B=0 writes LO=0xFFFFFFFF and HI=A for both DIV and DIVU, deterministic with no X.
  - Latency is identical either way.

## Test plan
- Reset, then MULT A=0xFFFFFFFE (−2), B=3 → Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=2 → after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU A=7, B=0:
  - With MDU_DIVZERO_KEEP_EN: HI/LO unchanged.
  - Without it: LO=0xFFFFFFFF, HI=7.
- MULT started with DMdUse=1 held → MdStall=1 for exactly 6 cycles (T … T+5). A second MULT presented while Busy is ignored, and the result matches the first op only.
- MTHI A=0x12345678 in IDLE → HI=0x12345678 next cycle, Busy stays 0. MTLO while Busy → LO unaffected by MTLO.
- Assert reset at cycle T+3 of a DIV → Busy=0 and HI=LO=0 immediately; no write after reset releases.
